// File: rtl/zion_basic_circuit_lib_shared_reg_arb.sv
// Round-robin write arbiter with an integrated shared register.
// Requesters load data or clear the register, and may lock ownership across writes.
module zion_basic_circuit_lib_shared_reg_arb #(
    parameter int              NUM_REQ  = 4,
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iClr,
    input  logic [NUM_REQ-1:0]         iReqVld,
    input  logic [NUM_REQ-1:0]         iReqClr,
    input  logic [NUM_REQ-1:0]         iReqLock,
    input  logic [NUM_REQ*WIDTH-1:0]   iReqDat,
    output logic [NUM_REQ-1:0]         oGnt,
    output logic [WIDTH-1:0]           oDat,
    output logic                       oUpdVld,
    output logic [$clog2(NUM_REQ)-1:0] oOwner
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    generate
        if (NUM_REQ < 2) begin : gNumReqCheck
            $error("zion_basic_circuit_lib_shared_reg_arb: NUM_REQ must be at least 2");
        end
    endgenerate

    logic [0:0]           stateR;
    logic [IDXW-1:0]      ptrR;
    logic [2*NUM_REQ-1:0] dblS;
    logic [IDXW-1:0]      offS;
    logic [IDXW:0]        sumS;
    logic [IDXW-1:0]      winIdxS;
    logic [IDXW-1:0]      xferIdxS;
    logic [NUM_REQ-1:0]   gntS;
    logic                 xferS;
    logic [WIDTH-1:0]     datS;

    // Round-robin search: rotate requests so ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        dblS = {iReqVld, iReqVld} >> ptrR;
        offS = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            offS = dblS[k] ? IDXW'(k) : offS;
        end
        sumS    = {1'b0, ptrR} + {1'b0, offS};
        winIdxS = (sumS >= (IDXW + 1)'(NUM_REQ)) ? IDXW'(sumS - (IDXW + 1)'(NUM_REQ))
                                                 : sumS[IDXW-1:0];
    end

    // Grant decode; while locked oOwner is the lock holder, since entering LOCK
    // always comes with a transfer that loads oOwner.
    always_comb begin
        gntS     = '0;
        xferIdxS = winIdxS;
        if (iClr) begin
            gntS = '0;
        end else if (stateR == ST_LOCK) begin
            xferIdxS       = oOwner;
            gntS[oOwner]   = iReqVld[oOwner];
        end else if (|iReqVld) begin
            gntS[winIdxS]  = 1'b1;
        end else begin
            gntS = '0;
        end
        xferS = |(gntS & iReqVld);
        datS  = iReqClr[xferIdxS] ? INI_DATA : iReqDat[xferIdxS*WIDTH +: WIDTH];
    end

    assign oGnt = gntS;

    // Register, pointer, owner and lock state update.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateR  <= ST_ARB;
            ptrR    <= '0;
            oDat    <= INI_DATA;
            oUpdVld <= 1'b0;
            oOwner  <= '0;
        end else if (iClr) begin
            stateR  <= ST_ARB;
            oDat    <= INI_DATA;
            oUpdVld <= 1'b0;
        end else if (xferS) begin
            oDat    <= datS;
            oUpdVld <= 1'b1;
            oOwner  <= xferIdxS;
            ptrR    <= (xferIdxS == IDXW'(NUM_REQ - 1)) ? '0 : xferIdxS + IDXW'(1);
            stateR  <= iReqLock[xferIdxS] ? ST_LOCK : ST_ARB;
        end else begin
            oUpdVld <= 1'b0;
            // Owner idle with lock dropped releases the lock without a transfer.
            if (stateR == ST_LOCK && !iReqLock[oOwner]) begin
                stateR <= ST_ARB;
            end else begin
                stateR <= stateR;
            end
        end
    end

endmodule

// File: tb/tb_zion_basic_circuit_lib_shared_reg_arb.sv
// Self-checking bench for the shared-register arbiter: directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_zion_basic_circuit_lib_shared_reg_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        iClr;
    logic [3:0]  reqVld, reqClr, reqLock;
    logic [31:0] reqDat;
    logic [3:0]  gnt;
    logic [7:0]  dat;
    logic        upd;
    logic [1:0]  owner;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int         mPtr, mOwner, mLastOwner;
    bit         mLocked;
    logic [7:0] mDat;
    bit         mUpd;

    zion_basic_circuit_lib_shared_reg_arb #(.NUM_REQ(4), .WIDTH(8), .INI_DATA(8'h00)) dut (
        .clk(clk), .rst(rst), .iClr(iClr),
        .iReqVld(reqVld), .iReqClr(reqClr), .iReqLock(reqLock), .iReqDat(reqDat),
        .oGnt(gnt), .oDat(dat), .oUpdVld(upd), .oOwner(owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reqVld = 4'h0; reqClr = 4'h0; reqLock = 4'h0; iClr = 1'b0; rst = 1'b0;
    endtask

    function automatic logic [3:0] modelGnt();
        if (iClr) return 4'h0;
        if (mLocked) return reqVld[mOwner] ? (4'b0001 << mOwner) : 4'h0;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (mPtr + k) % 4;
            if (reqVld[i]) return 4'b0001 << i;
        end
        return 4'h0;
    endfunction

    task automatic modelStep(input logic [3:0] g);
        int w;
        w = -1;
        for (int i = 0; i < 4; i++) if (g[i] && reqVld[i]) w = i;
        if (rst) begin
            mPtr = 0; mLocked = 0; mDat = 8'h00; mUpd = 0; mLastOwner = 0; mOwner = 0;
        end else if (iClr) begin
            mDat = 8'h00; mUpd = 0; mLocked = 0;
        end else if (w >= 0) begin
            mDat = reqClr[w] ? 8'h00 : reqDat[w*8 +: 8];
            mUpd = 1; mLastOwner = w; mPtr = (w + 1) % 4;
            mLocked = reqLock[w]; mOwner = w;
        end else begin
            mUpd = 0;
            if (mLocked && !reqLock[mOwner]) mLocked = 0;
        end
    endtask

    task automatic test_reset();
        idle(); reqDat = 32'h0; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (dat !== 8'h00) begin failures++; $display("FAIL reset_dat got %h want 00", dat); end
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL reset_upd got %b want 0", upd); end
        checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner got %0d want 0", owner); end
        checks++; if (gnt !== 4'h0) begin failures++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    endtask

    task automatic test_round_robin();
        reqDat = 32'h13121110; reqVld = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (gnt !== (4'b0001 << k)) begin failures++; $display("FAIL rr_gnt%0d got %b want %b", k, gnt, 4'b0001 << k); end
            tick();
            checks++; if (dat !== 8'h10 + 8'(k)) begin failures++; $display("FAIL rr_dat%0d got %h want %h", k, dat, 8'h10 + 8'(k)); end
            checks++; if (upd !== 1'b1) begin failures++; $display("FAIL rr_upd%0d got %b want 1", k, upd); end
            checks++; if (owner !== 2'(k)) begin failures++; $display("FAIL rr_owner%0d got %0d want %0d", k, owner, k); end
        end
        reqVld = 4'h0;
        tick();
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL rr_upd_drop got %b want 0", upd); end
    endtask

    task automatic test_wrap();
        int exp [3] = '{3, 0, 1};
        reqVld = 4'b0010;
        tick();
        reqVld = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (gnt !== (4'b0001 << exp[k])) begin failures++; $display("FAIL wrap_gnt%0d got %b want %b", k, gnt, 4'b0001 << exp[k]); end
            tick();
        end
        reqVld = 4'h0;
        tick();
    endtask

    task automatic test_lock();
        reqDat = 32'h00AA0000; reqVld = 4'b0100; reqLock = 4'b0100;
        #1;
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL lock_first_gnt got %b want 0100", gnt); end
        tick();
        checks++; if (dat !== 8'hAA) begin failures++; $display("FAIL lock_dat got %h want aa", dat); end
        reqVld = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            reqDat = {8'h00, 8'hB0 + 8'(k), 8'h55, 8'h66};
            #1;
            checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL lock_hold_gnt%0d got %b want 0100", k, gnt); end
            tick();
            checks++; if (dat !== 8'hB0 + 8'(k)) begin failures++; $display("FAIL lock_hold_dat%0d got %h want %h", k, dat, 8'hB0 + 8'(k)); end
        end
        reqLock = 4'b0000;
        tick();
        #1;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL lock_after_release got %b want 0001", gnt); end
        // ptr now 1: one transfer by 0, then requester 1 locks and goes idle
        tick();
        reqVld = 4'b0010; reqLock = 4'b0010;
        tick();
        reqVld = 4'b1000;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL lock_idle_hold got %b want 0000", gnt); end
        tick();
        reqLock = 4'b0000;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL lock_exit_cycle got %b want 0000", gnt); end
        tick();
        checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL lock_exit_next got %b want 1000", gnt); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_clear();
        reqDat = 32'h0000005A; reqVld = 4'b0001;
        tick();
        checks++; if (dat !== 8'h5A) begin failures++; $display("FAIL clr_pre_dat got %h want 5a", dat); end
        reqVld = 4'b1000; reqClr = 4'b1000; reqDat = 32'hFF00005A;
        tick();
        checks++; if (dat !== 8'h00) begin failures++; $display("FAIL reqclr_dat got %h want 00", dat); end
        checks++; if (owner !== 2'd3) begin failures++; $display("FAIL reqclr_owner got %0d want 3", owner); end
        checks++; if (upd !== 1'b1) begin failures++; $display("FAIL reqclr_upd got %b want 1", upd); end
        reqClr = 4'h0; reqVld = 4'b0010; reqDat = 32'h00007700;
        tick();
        checks++; if (dat !== 8'h77) begin failures++; $display("FAIL clr_setup_dat got %h want 77", dat); end
        iClr = 1'b1; reqDat = 32'h00003300;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL gclr_gnt got %b want 0000", gnt); end
        tick();
        checks++; if (dat !== 8'h00) begin failures++; $display("FAIL gclr_dat got %h want 00", dat); end
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL gclr_upd got %b want 0", upd); end
        checks++; if (owner !== 2'd1) begin failures++; $display("FAIL gclr_owner got %0d want 1", owner); end
        iClr = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL gclr_held_gnt got %b want 0010", gnt); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_reset_in_lock();
        reqDat = 32'h00003300; reqVld = 4'b0010; reqLock = 4'b0010;
        tick();
        reqVld = 4'h0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (dat !== 8'h00) begin failures++; $display("FAIL rstlock_dat got %h want 00", dat); end
        checks++; if (owner !== 2'd0) begin failures++; $display("FAIL rstlock_owner got %0d want 0", owner); end
        reqVld = 4'hF; reqLock = 4'h0;
        #1;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rstlock_gnt got %b want 0001", gnt); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        logic [3:0] eg;
        idle(); rst = 1'b1;
        tick();
        mPtr = 0; mLocked = 0; mDat = 8'h00; mUpd = 0; mLastOwner = 0; mOwner = 0;
        rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            reqVld  = 4'($urandom_range(0, 15));
            reqClr  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            reqLock = 4'($urandom_range(0, 15));
            reqDat  = $urandom;
            iClr    = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 49) == 0);
            #1;
            eg = modelGnt();
            checks++; if (gnt !== eg) begin failures++; $display("FAIL rand_gnt n=%0d got %b want %b", n, gnt, eg); end
            modelStep(eg);
            tick();
            checks++; if (dat !== mDat) begin failures++; $display("FAIL rand_dat n=%0d got %h want %h", n, dat, mDat); end
            checks++; if (upd !== mUpd) begin failures++; $display("FAIL rand_upd n=%0d got %b want %b", n, upd, mUpd); end
            checks++; if (owner !== 2'(mLastOwner)) begin failures++; $display("FAIL rand_owner n=%0d got %0d want %0d", n, owner, mLastOwner); end
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap();
        test_lock();
        test_clear();
        test_reset_in_lock();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
